// File: rtl/aor_key_loader.sv
// aor_key_loader: parity-checked, checksum-verified key delivery that drives a decoy until armed
module aor_key_loader #(
  parameter int KEY_BYTES = 8,
  parameter logic [8*KEY_BYTES-1:0] DECOY = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [7:0]             byte_i,
  input  logic                   byte_par_i,
  input  logic                   byte_valid_i,
  output logic                   byte_ready_o,
  output logic [8*KEY_BYTES-1:0] keyinput,
  output logic                   key_valid_o,
  output logic                   key_err_o,
  output logic                   busy_o
);
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, ARMED, ERROR} state_t;
  state_t state_q, state_d;
  logic [8*KEY_BYTES-1:0] shadow_q, shadow_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] acc_q, acc_d, csum_q, csum_d;
  logic accept, par_ok, last_beat;
  assign accept    = (state_q == LOAD) && byte_valid_i;
  assign par_ok    = ^{byte_i, byte_par_i};
  assign last_beat = cnt_q == 4'(KEY_BYTES);
  // state and datapath registers, cleared asynchronously so a partial key never survives reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      csum_q   <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      csum_q   <= csum_d;
    end
  end
  // next state: start is honoured only from IDLE, ARMED and ERROR
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start_i ? LOAD : IDLE;
      LOAD:    state_d = !accept ? LOAD : !par_ok ? ERROR : last_beat ? CHECK : LOAD;
      CHECK:   state_d = (acc_q == csum_q) ? ARMED : ERROR;
      ARMED:   state_d = start_i ? LOAD : ARMED;
      ERROR:   state_d = start_i ? LOAD : ERROR;
      default: state_d = IDLE;
    endcase
  end
  // datapath: clear on load entry, capture good beats, wipe shadow when entering ERROR
  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    csum_d   = csum_q;
    if (state_d == LOAD && state_q != LOAD) begin
      shadow_d = '0;
      cnt_d    = '0;
      acc_d    = '0;
    end else if (accept && par_ok) begin
      if (last_beat) csum_d = byte_i;
      else begin
        for (int k = 0; k < KEY_BYTES; k++)
          if (cnt_q == 4'(k)) shadow_d[8*k +: 8] = byte_i;
        acc_d = acc_q ^ byte_i;
        cnt_d = cnt_q + 4'd1;
      end
    end
    if (state_d == ERROR && state_q != ERROR) shadow_d = '0;
  end
  // outputs decoded purely from registered state
  always_comb begin
    byte_ready_o = state_q == LOAD;
    key_valid_o  = state_q == ARMED;
    key_err_o    = state_q == ERROR;
    busy_o       = (state_q == LOAD) || (state_q == CHECK);
    keyinput     = (state_q == ARMED) ? shadow_q : DECOY;
  end
endmodule

// File: tb/tb_aor_key_loader.sv
// tb_aor_key_loader: table-driven load vectors with a scoreboard of expected outcomes
module tb_aor_key_loader;
  localparam logic [63:0] DECOY = 64'h0;
  logic clk = 1'b0, rst, start_i, byte_par_i, byte_valid_i;
  logic byte_ready_o, key_valid_o, key_err_o, busy_o;
  logic [7:0] byte_i;
  logic [63:0] keyinput;
  int checks = 0, errors = 0;
  typedef struct {
    logic [8:0][7:0] data;
    int bad;
    bit gap;
    bit late;
    logic [63:0] key;
    bit ok;
    int lat;
  } vec_t;
  vec_t vecs[7];
  vec_t exp_q[$];

  aor_key_loader dut (
    .clk(clk), .rst(rst), .start_i(start_i), .byte_i(byte_i), .byte_par_i(byte_par_i),
    .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o), .keyinput(keyinput),
    .key_valid_o(key_valid_o), .key_err_o(key_err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {63'h0, act}, {63'h0, exp});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_key"}, keyinput, DECOY);
    chk1({tag, "_ready"}, byte_ready_o, 1'b0);
    chk1({tag, "_valid"}, key_valid_o, 1'b0);
    chk1({tag, "_err"}, key_err_o, 1'b0);
    chk1({tag, "_busy"}, busy_o, 1'b0);
  endtask

  task automatic run(input vec_t v);
    int i = 0, n = 0;
    bit done = 0;
    vec_t e;
    logic [63:0] key_end;
    @(posedge clk); #1;
    start_i = 1'b1;
    byte_valid_i = 1'b0;
    exp_q.push_back(v);
    @(posedge clk); #1;
    start_i = 1'b0;
    n = 1;
    chk1("busy_after_start", busy_o, 1'b1);
    chk1("valid_after_start", key_valid_o, 1'b0);
    chk("key_after_start", keyinput, DECOY);
    while (!done && n < 60) begin
      if (key_valid_o || key_err_o) done = 1;
      else begin
        chk("key_decoy_while_busy", keyinput, DECOY);
        if (i == 9) chk1("ready_after_last_beat", byte_ready_o, 1'b0);
        byte_valid_i = (i < 9) && (!v.gap || n % 3 == 1);
        byte_i = (i < 9) ? v.data[i] : 8'h00;
        byte_par_i = (~^byte_i) ^ (i == v.bad);
        start_i = v.late && i >= 8;
        if (byte_valid_i && byte_ready_o) i++;
        @(posedge clk); #1;
        n++;
      end
    end
    start_i = 1'b0;
    byte_valid_i = 1'b0;
    e = exp_q.pop_front();
    chk1("finished_in_budget", done, 1'b1);
    chk("final_key", keyinput, e.ok ? e.key : DECOY);
    chk1("final_valid", key_valid_o, e.ok);
    chk1("final_err", key_err_o, !e.ok);
    chk1("final_ready", byte_ready_o, 1'b0);
    if (e.lat > 0) chk("latency", 64'(n), 64'(e.lat));
    key_end = keyinput;
    for (int c = 0; c < 3; c++) begin
      byte_valid_i = 1'b1;
      byte_i = 8'h5A;
      byte_par_i = 1'b1;
      @(posedge clk); #1;
      chk1("hold_ready", byte_ready_o, 1'b0);
      chk1("hold_busy", busy_o, 1'b0);
      chk("hold_key", keyinput, key_end);
    end
    byte_valid_i = 1'b0;
  endtask

  initial begin
    vecs[0] = '{data: {8'h00, 64'hEFCDAB8967452301}, bad: -1, gap: 0, late: 0, key: 64'hEFCDAB8967452301, ok: 1, lat: 11};
    vecs[1] = '{data: {8'h01, 64'hEFCDAB8967452301}, bad: -1, gap: 0, late: 0, key: 64'h0, ok: 0, lat: 11};
    vecs[2] = '{data: {8'h00, 64'hEFCDAB8967452301}, bad: 3, gap: 0, late: 0, key: 64'h0, ok: 0, lat: 5};
    vecs[3] = '{data: {8'h00, 64'hEFCDAB8967452301}, bad: -1, gap: 1, late: 0, key: 64'hEFCDAB8967452301, ok: 1, lat: -1};
    vecs[4] = '{data: {8'h00, 64'h0123456789ABCDEF}, bad: -1, gap: 0, late: 0, key: 64'h0123456789ABCDEF, ok: 1, lat: 11};
    vecs[5] = '{data: {8'h88, 64'h8877665544332211}, bad: -1, gap: 0, late: 0, key: 64'h8877665544332211, ok: 1, lat: 11};
    vecs[6] = '{data: {8'h00, 64'hEFCDAB8967452301}, bad: -1, gap: 0, late: 1, key: 64'hEFCDAB8967452301, ok: 1, lat: 11};
    rst = 1'b1;
    start_i = 1'b0;
    byte_i = 8'h00;
    byte_par_i = 1'b0;
    byte_valid_i = 1'b0;
    #1;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs("idle");
    run(vecs[0]);
    run(vecs[1]);
    run(vecs[2]);
    run(vecs[3]);
    run(vecs[6]);
    run(vecs[5]);
    rst = 1'b1;
    #1;
    chk_reset_outputs("reset_in_armed");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int b = 0; b < 5; b++) begin
      byte_valid_i = 1'b1;
      byte_i = vecs[5].data[b];
      byte_par_i = ~^byte_i;
      @(posedge clk); #1;
    end
    byte_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_outputs("reset_mid_load");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk_reset_outputs("idle_after_reset");
    end
    run(vecs[4]);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aor_key_loader.md
# aor_key_loader

Sequential key-delivery unit for the AOR-locked arithmetic netlists, such as the 8x8 broken array multiplier with its 64-bit `keyinput` port. It receives the activation key from secure storage as a parity-protected byte stream with a valid/ready handshake, then verifies a trailing XOR checksum. Only on full success does it drive the key onto `keyinput`. In every other state it drives a fixed decoy word, so a partial or corrupted load never unlocks the netlist.

## Interface
- `KEY_BYTES`, default 8: number of key bytes; the key width is 8*KEY_BYTES (64).
- `DECOY`, default 64'h0: value driven on `keyinput` whenever not ARMED.
- `clk` input, 1: single clock; all state updates on the rising edge.
- `rst` input, 1: reset, asynchronous, active-high.
- `start_i` input, 1: request a (re)load of the key.
- `byte_i` input, 8: key byte, or checksum byte on the final beat.
- `byte_par_i` input, 1: odd-parity bit for `byte_i`.
- `byte_valid_i` input, 1: source has a byte on `byte_i`.
- `byte_ready_o` output, 1: loader accepts a byte this cycle.
- `keyinput` output, 64: key to the locked netlist.
- `key_valid_o` output, 1: high in ARMED only.
- `key_err_o` output, 1: high in ERROR only.
- `busy_o` output, 1: high in LOAD or CHECK.

## Operation
- FSM states: IDLE, LOAD, CHECK, ARMED, ERROR. All outputs are decoded from registered state. There is no combinational path from any input to any output.
- IDLE:
  - `start_i`=1 moves to LOAD.
  - On that transition, the shadow register is cleared to 0, the beat counter to 0, and the checksum accumulator to 0.
- LOAD: `byte_ready_o`=1. A beat is accepted when `byte_valid_i` and `byte_ready_o` are both 1.
  - Parity rule: `^{byte_i,byte_par_i}` must be 1. A failing beat moves the FSM to ERROR on the next edge, and that beat is discarded.
  - Beats 0..7 (counter values): byte k is written to `shadow[8k+7:8k]` (little-endian) and XORed into the accumulator.
  - Beat 8 is the checksum byte. It is latched into the compare register, and the FSM moves to CHECK.
  - `start_i` is ignored in LOAD and CHECK.
- CHECK: one cycle. If accumulator == checksum, the FSM moves to ARMED; otherwise it moves to ERROR.
- ARMED: `keyinput` = shadow and `key_valid_o`=1. `start_i`=1 moves to LOAD, clearing state exactly as from IDLE.
- ERROR: `keyinput` = DECOY and `key_err_o`=1. The shadow register is cleared to 0 on entry. `start_i`=1 moves to LOAD.
- `keyinput` = DECOY in IDLE, LOAD, CHECK and ERROR. It changes only on the edge that enters or leaves ARMED.
- Beat counter: 4 bits, 0..8, no wrap. It is reset to 0 on every LOAD entry.

## Timing
- Reset values: state=IDLE, `keyinput`=DECOY, `byte_ready_o`=0, `key_valid_o`=0, `key_err_o`=0, `busy_o`=0. Shadow, accumulator and counter are all 0.
- `start_i` sampled at edge t puts the FSM in LOAD from t+1, with `byte_ready_o`=1 from t+1.
- With continuous valid data, beats are accepted on edges t+1..t+9, CHECK runs at t+10, and ARMED (`keyinput` updated, `key_valid_o`=1) starts at t+11.
- Minimum load latency is 11 cycles from `start_i`. `byte_valid_i` gaps stall the counter, with no timeout.
- `byte_ready_o` drops in the cycle after the 9th accepted beat, and in the cycle after a parity failure.
- Reset asserted mid-LOAD or in ARMED:
  - Outputs return to reset values immediately (asynchronously).
  - The partial key is discarded.
  - After deassertion, the FSM waits in IDLE for `start_i`.
- A `start_i` asserted in the same cycle as the last beat, or during CHECK, has no effect.

## Test plan
- Normal load:
  - Stimulus: `start_i`, then bytes 01,23,45,67,89,AB,CD,EF, checksum 0x00, all with correct parity and valid held high.
  - Required: `keyinput`=64'hEFCDAB8967452301 and `key_valid_o`=1 exactly 11 cycles after start; `keyinput`=0 in every earlier cycle.
- Checksum fail:
  - Stimulus: same bytes with checksum 0x01.
  - Required: ERROR reached after CHECK, `key_err_o`=1, `keyinput`=DECOY, `key_valid_o` never asserted.
- Parity fail:
  - Stimulus: byte 3 = 0x67 with `byte_par_i`=1 (bad parity).
  - Required: `byte_ready_o`=0 and `key_err_o`=1 on the next cycle; remaining beats are not accepted.
- Backpressure and gaps:
  - Stimulus: `byte_valid_i` toggling 1,0,0,1,... through a valid load.
  - Required: the same final key as the normal-load test; only the latency grows, and the counter never advances on a 0 beat.
- Reset mid-operation:
  - Stimulus: `rst` pulsed after 5 beats, then a fresh `start_i` and a full valid load with key 64'h0123456789ABCDEF.
  - Required: all outputs are at reset values during `rst`; the final key is exactly the new value, with no stale bytes.
- Reload from ARMED:
  - Stimulus: `start_i` while ARMED.
  - Required: `key_valid_o` falls and `keyinput` returns to DECOY on the next edge; `busy_o`=1 until the new load completes.
